// File: rtl/modadd_ctrl_if.sv
// modadd_ctrl_if
//   Groups the request/response signals of the modular add/subtract
//   controller together with its link to the external multi-precision
//   adder (mpadder).
//   Request side : start, op_sub, in_a, in_b, in_m -> result, done, busy
//   Adder side   : add_start, add_subtract, add_a, add_b -> add_result, add_done
//   slave  : view of the controller
//   master : view of whoever drives requests and plays the adder
interface modadd_ctrl_if #(
    parameter int OPW = 1024
);
    logic            start;
    logic            op_sub;
    logic [OPW-1:0]  in_a;
    logic [OPW-1:0]  in_b;
    logic [OPW-1:0]  in_m;
    logic [OPW-1:0]  result;
    logic            done;
    logic            busy;

    logic            add_start;
    logic            add_subtract;
    logic [1026:0]   add_a;
    logic [1026:0]   add_b;
    logic [1027:0]   add_result;
    logic            add_done;

    modport slave (
        input  start, op_sub, in_a, in_b, in_m, add_result, add_done,
        output result, done, busy, add_start, add_subtract, add_a, add_b
    );

    modport master (
        output start, op_sub, in_a, in_b, in_m, add_result, add_done,
        input  result, done, busy, add_start, add_subtract, add_a, add_b
    );
endinterface

// File: rtl/modadd_ctrl.sv
// modadd_ctrl
//   Computes (a + b) mod M or (a - b) mod M for a < M, b < M, M > 1 using
//   two passes through an external mpadder. The second pass (reduction or
//   correction) always runs so the cycle count never depends on the data.
//   Ports:
//     i_clk    - system clock, rising edge
//     i_resetn - asynchronous active-low reset
//     bus      - modadd_ctrl_if.slave (request/response + mpadder link)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; operands captured on accept
//   OP1    | add_start pulse: a +/- b
//   W1     | waiting for adder; latch T on add_done
//   OP2    | add_start pulse: T - M (add) or T + M (sub)
//   W2     | waiting for adder; pick result on add_done
//   FIN    | done pulse, result valid
module modadd_ctrl #(
    parameter int OPW = 1024
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    modadd_ctrl_if.slave bus
);
    localparam int AW   = 1027;
    localparam int PADW = AW - OPW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP1,
        S_W1,
        S_OP2,
        S_W2,
        S_FIN
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [OPW-1:0] r_m;
    logic           r_op_sub;
    logic           r_t_sign;
    logic [OPW-1:0] r_t_low;
    logic [OPW-1:0] r_result;
    logic [AW-1:0]  r_add_a;
    logic [AW-1:0]  r_add_b;
    logic           r_add_sub;

    logic           w_add_start;
    logic           w_done;
    logic           w_busy;
    logic [OPW-1:0] w_sel;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_add_start = 1'b0;
        w_done      = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_state_nxt = S_OP1;
            end
            S_OP1: begin
                w_add_start = 1'b1;
                w_state_nxt = S_W1;
            end
            S_W1: begin
                if (bus.add_done) w_state_nxt = S_OP2;
            end
            S_OP2: begin
                w_add_start = 1'b1;
                w_state_nxt = S_W2;
            end
            S_W2: begin
                if (bus.add_done) w_state_nxt = S_FIN;
            end
            S_FIN: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // add: a negative T-M (bit 1027 set) means T was already reduced.
    // sub: a negative a-b needs the T+M correction from the second pass.
    always_comb begin
        if (r_op_sub) begin
            w_sel = r_t_sign ? bus.add_result[OPW-1:0] : r_t_low;
        end else begin
            w_sel = bus.add_result[AW] ? r_t_low : bus.add_result[OPW-1:0];
        end
    end

    // Adder operands live in registers so they stay put from the OP state
    // until the add_done cycle; they only move on accept or on add_done.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_m       <= '0;
            r_op_sub  <= 1'b0;
            r_t_sign  <= 1'b0;
            r_t_low   <= '0;
            r_result  <= '0;
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_sub <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_m       <= bus.in_m;
                        r_op_sub  <= bus.op_sub;
                        r_add_a   <= {{PADW{1'b0}}, bus.in_a};
                        r_add_b   <= {{PADW{1'b0}}, bus.in_b};
                        r_add_sub <= bus.op_sub;
                    end
                end
                S_W1: begin
                    if (bus.add_done) begin
                        r_t_sign  <= bus.add_result[AW];
                        r_t_low   <= bus.add_result[OPW-1:0];
                        r_add_a   <= bus.add_result[AW-1:0];
                        r_add_b   <= {{PADW{1'b0}}, r_m};
                        r_add_sub <= ~r_op_sub;
                    end
                end
                S_W2: begin
                    if (bus.add_done) r_result <= w_sel;
                end
                default: ;
            endcase
        end
    end

    assign bus.result       = r_result;
    assign bus.done         = w_done;
    assign bus.busy         = w_busy;
    assign bus.add_start    = w_add_start;
    assign bus.add_subtract = r_add_sub;
    assign bus.add_a        = r_add_a;
    assign bus.add_b        = r_add_b;
endmodule

// File: tb/tb_modadd_ctrl.sv
// tb_modadd_ctrl
//   Directed and random requests against modadd_ctrl. A negedge-driven
//   mpadder model answers adder requests with a per-operation latency and
//   watches the adder handshake; results are compared with plain modular
//   arithmetic.
module tb_modadd_ctrl;
    localparam int OPW = 1024;
    localparam int NW  = (OPW + 31) / 32;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    modadd_ctrl_if #(.OPW(OPW)) bus ();

    modadd_ctrl #(.OPW(OPW)) u_dut (
        .i_clk    (clk),
        .i_resetn (resetn),
        .bus      (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int lat1     = 1;
    int lat2     = 1;
    int n_starts = 0;

    task automatic chk(input string tag, input logic [1027:0] obs, input logic [1027:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (low 128 bits%s)", tag, obs[127:0], exp[127:0],
                   (((obs ^ exp) >> 128) != 0) ? ", upper bits differ" : "");
        end
    endtask

    function automatic logic [OPW-1:0] rand_w();
        logic [NW*32-1:0] t;
        for (int i = 0; i < NW; i++) t[i*32 +: 32] = $urandom;
        return t[OPW-1:0];
    endfunction

    function automatic logic [OPW-1:0] ref_mod(input logic sub, input logic [OPW-1:0] a,
                                               input logic [OPW-1:0] b, input logic [OPW-1:0] m);
        logic [OPW:0] s;
        if (!sub) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, m}) s = s - {1'b0, m};
        end else if (a >= b) begin
            s = {1'b0, a} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, m} - {1'b0, b};
        end
        return s[OPW-1:0];
    endfunction

    // mpadder model: a pulse seen at a negedge is sampled by the next rising
    // edge; add_done is then raised so it is sampled lat edges later.
    initial begin
        int            cnt;
        int            op_idx;
        logic [1026:0] cap_a;
        logic [1026:0] cap_b;
        logic          cap_sub;
        logic [1027:0] pend;
        cnt = 0;
        op_idx = 0;
        cap_a = '0;
        cap_b = '0;
        cap_sub = 1'b0;
        pend = '0;
        bus.add_done   = 1'b0;
        bus.add_result = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                cnt = 0;
                op_idx = 0;
                bus.add_done = 1'b0;
            end else begin
                bus.add_done = 1'b0;
                if (cnt > 0) begin
                    chk("add_a_stable", 1028'(bus.add_a), 1028'(cap_a));
                    chk("add_b_stable", 1028'(bus.add_b), 1028'(cap_b));
                    chk("add_sub_stable", 1028'(bus.add_subtract), 1028'(cap_sub));
                    cnt--;
                    if (cnt == 0) begin
                        bus.add_done   = 1'b1;
                        bus.add_result = pend;
                    end
                end
                if (bus.add_start === 1'b1) begin
                    n_starts++;
                    chk("add_start_overlap", 1028'(bus.add_done || (cnt != 0)), 1028'(0));
                    cap_a   = bus.add_a;
                    cap_b   = bus.add_b;
                    cap_sub = bus.add_subtract;
                    pend    = cap_sub ? ({1'b0, cap_a} - {1'b0, cap_b}) : ({1'b0, cap_a} + {1'b0, cap_b});
                    cnt     = (op_idx % 2 == 0) ? lat1 : lat2;
                    op_idx++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_done"}, 1028'(bus.done), 1028'(0));
        chk({tag, "_busy"}, 1028'(bus.busy), 1028'(0));
        chk({tag, "_add_start"}, 1028'(bus.add_start), 1028'(0));
        chk({tag, "_add_subtract"}, 1028'(bus.add_subtract), 1028'(0));
        chk({tag, "_result"}, 1028'(bus.result), 1028'(0));
        chk({tag, "_add_a"}, 1028'(bus.add_a), 1028'(0));
        chk({tag, "_add_b"}, 1028'(bus.add_b), 1028'(0));
    endtask

    // Returns the negedge index (1 = first negedge after the start edge)
    // where done is first seen.
    task automatic wait_done(output int ncyc);
        ncyc = 1;
        while (bus.done !== 1'b1 && ncyc < 200) begin
            @(negedge clk);
            ncyc++;
        end
        chk("done_seen", 1028'(bus.done), 1028'(1));
        chk("busy_in_done", 1028'(bus.busy), 1028'(1));
    endtask

    task automatic run_op(input logic sub, input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                          input logic [OPW-1:0] m, input int l1, input int l2,
                          output logic [OPW-1:0] res, output int ncyc);
        lat1 = l1;
        lat2 = l2;
        n_starts = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_sub = sub;
        bus.in_a   = a;
        bus.in_b   = b;
        bus.in_m   = m;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 1028'(bus.busy), 1028'(1));
        wait_done(ncyc);
        res = bus.result;
        @(negedge clk);
        chk("done_one_cycle", 1028'(bus.done), 1028'(0));
        chk("busy_low_after", 1028'(bus.busy), 1028'(0));
        chk("two_add_starts", 1028'(n_starts), 1028'(2));
    endtask

    initial begin
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic [OPW-1:0] m;
        logic [OPW-1:0] res;
        logic           sub;
        int             n;
        int             n_ref;
        int             l1;
        int             l2;

        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.in_a   = '0;
        bus.in_b   = '0;
        bus.in_m   = '0;

        #2;
        chk_zero_outs("rst");
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // 7 + 9 mod 13
        run_op(1'b0, OPW'(7), OPW'(9), OPW'(13), 2, 3, res, n);
        chk("add_7_9", 1028'(res), 1028'(3));
        chk("lat_7_9", 1028'(n), 1028'(2 + 3 + 3));
        @(negedge clk);
        chk("result_held", 1028'(bus.result), 1028'(3));

        run_op(1'b0, OPW'(2), OPW'(5), OPW'(13), 3, 3, res, n_ref);
        chk("add_2_5", 1028'(res), 1028'(7));
        chk("lat_2_5", 1028'(n_ref), 1028'(9));
        run_op(1'b0, OPW'(6), OPW'(7), OPW'(13), 1, 1, res, n);
        chk("add_sum_eq_m", 1028'(res), 1028'(0));
        chk("lat_1_1", 1028'(n), 1028'(5));

        run_op(1'b1, OPW'(4), OPW'(8), OPW'(13), 1, 2, res, n);
        chk("sub_4_8", 1028'(res), 1028'(9));
        run_op(1'b1, OPW'(8), OPW'(4), OPW'(13), 2, 1, res, n);
        chk("sub_8_4", 1028'(res), 1028'(4));
        run_op(1'b1, OPW'(5), OPW'(5), OPW'(13), 4, 4, res, n);
        chk("sub_5_5", 1028'(res), 1028'(0));
        chk("lat_4_4", 1028'(n), 1028'(11));

        // largest modulus, same adder latency as the 2+5 case
        m = '1;
        run_op(1'b0, m - OPW'(1), m - OPW'(1), m, 3, 3, res, n);
        chk("add_max", 1028'(res), 1028'(m - OPW'(2)));
        chk("lat_max_eq", 1028'(n), 1028'(n_ref));

        // start storms during W1 and in FIN
        lat1 = 4;
        lat2 = 2;
        n_starts = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_sub = 1'b0;
        bus.in_a   = OPW'(7);
        bus.in_b   = OPW'(9);
        bus.in_m   = OPW'(13);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.op_sub = 1'b1;
        bus.in_a   = OPW'(1);
        bus.in_b   = OPW'(2);
        n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n++;
            bus.start = (k != 1);
        end
        @(negedge clk);
        n++;
        bus.start = 1'b0;
        begin
            int nw;
            wait_done(nw);
            n = n + nw - 1;
        end
        chk("storm_result", 1028'(bus.result), 1028'(3));
        chk("storm_latency", 1028'(n), 1028'(4 + 2 + 3));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("fin_start_ignored", 1028'(bus.busy), 1028'(0));
        chk("storm_single_done", 1028'(bus.done), 1028'(0));
        repeat (2) @(negedge clk);
        chk("storm_still_idle", 1028'(bus.busy), 1028'(0));
        chk("storm_two_add_starts", 1028'(n_starts), 1028'(2));
        run_op(1'b1, OPW'(8), OPW'(4), OPW'(13), 1, 1, res, n);
        chk("after_storm", 1028'(res), 1028'(4));

        // reset during W2
        lat1 = 2;
        lat2 = 6;
        n_starts = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_sub = 1'b0;
        bus.in_a   = OPW'(11);
        bus.in_b   = OPW'(12);
        bus.in_m   = OPW'(13);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("w2_busy", 1028'(bus.busy), 1028'(1));
        chk("w2_second_op_issued", 1028'(n_starts), 1028'(2));
        #2;
        resetn = 1'b0;
        #1;
        chk_zero_outs("mid_rst");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 4) begin
                #2;
                resetn = 1'b1;
            end
            if (bus.done !== 1'b0) chk("no_done_after_rst", 1028'(bus.done), 1028'(0));
        end
        chk("idle_after_rst", 1028'(bus.busy), 1028'(0));
        run_op(1'b0, OPW'(7), OPW'(9), OPW'(13), 2, 2, res, n);
        chk("add_after_rst", 1028'(res), 1028'(3));

        // random requests
        for (int i = 0; i < 16; i++) begin
            if (i < 6) begin
                m = OPW'($urandom_range(2, 20));
            end else begin
                m = rand_w();
                if (m < OPW'(2)) m = OPW'(2);
            end
            a   = rand_w() % m;
            b   = rand_w() % m;
            sub = 1'($urandom_range(0, 1));
            l1  = $urandom_range(1, 4);
            l2  = $urandom_range(1, 4);
            run_op(sub, a, b, m, l1, l2, res, n);
            chk("rand_result", 1028'(res), 1028'(ref_mod(sub, a, b, m)));
            chk("rand_latency", 1028'(n), 1028'(l1 + l2 + 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/modadd_ctrl.md
MODADD_CTRL -- requirements
Module: modadd_ctrl

Interface
REQ-001 Parameter: OPW, 1024, modular operand width in bits; legal range 2..1026.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op_sub  input  1  0 = modular add, 1 = modular subtract; captured with start.
REQ-006 in_a, in_b, in_m  input  OPW each  operands and modulus; captured with start; caller guarantees a<M, b<M, M>1.
REQ-007 result  output  OPW  modular result; valid while done=1, held until next accepted start.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 busy  output  1  high from cycle after accepted start through the done cycle.
REQ-010 add_start  output  1  one-cycle start pulse to external mpadder.
REQ-011 add_subtract  output  1  mpadder subtract select; stable while adder op in flight.
REQ-012 add_a, add_b  output  1027 each  mpadder operands; OPW values zero-extended; stable while adder op in flight.
REQ-013 add_result  input  1028  mpadder result; bit 1027 = carry (add) or sign of two's-complement difference (sub).
REQ-014 add_done  input  1  mpadder completion pulse.

Function
REQ-015 FSM states: IDLE, OP1, W1, OP2, W2, FIN.
REQ-016 IDLE: start=1 -> capture a, b, M, op_sub; go OP1; start while not IDLE is ignored, not queued.
REQ-017 OP1 (1 cycle): add_start=1; add_a=a, add_b=b, add_subtract=op_sub; go W1.
REQ-018 W1: wait for add_done; on add_done register T=add_result; go OP2; add_done in any state other than W1/W2 is ignored.
REQ-019 OP2 (1 cycle): add_start=1; add: add_a=T[1026:0], add_b=M, add_subtract=1; sub: add_a=T[1026:0], add_b=M, add_subtract=0.
REQ-020 W2: on add_done register U=add_result; go FIN.
REQ-021 Result select, add: U[1027]=1 (T<M) -> result=T[OPW-1:0], else result=U[OPW-1:0].
REQ-022 Result select, sub: T[1027]=1 (a<b) -> result=U[OPW-1:0] (T+M), else result=T[OPW-1:0].
REQ-023 Second adder operation always executed regardless of first result (constant-time, no data-dependent cycle count).
REQ-024 FIN (1 cycle): done=1, result driven; go IDLE; start in FIN is ignored.
REQ-025 Latency: done asserted L1+L2+3 cycles after the edge sampling start, L1/L2 = cycles from add_start to add_done of each adder op.
REQ-026 add_a/add_b/add_subtract held constant from OP state through cycle add_done is sampled.
REQ-027 add_start never asserted in same cycle add_done is sampled; never two add_start pulses without intervening add_done.

Reset
REQ-028 resetn=0 forces immediately: state IDLE, done=0, busy=0, add_start=0, add_subtract=0, result=0, add_a=0, add_b=0, internal T/U=0.
REQ-029 Reset mid-operation abandons request; no done pulse; first start after release is accepted normally.

Verification
REQ-030 M=13, add a=7,b=9 -> result=3, done one cycle, busy low after; exactly two add_start pulses.
REQ-031 M=13, add a=2,b=5 -> result=7; add a=6,b=7 (sum=M) -> result=0.
REQ-032 M=13, sub a=4,b=8 -> result=9; sub a=8,b=4 -> result=4; sub a=5,b=5 -> 0.
REQ-033 M=2^OPW-1, add a=M-1,b=M-1 -> result=M-2; identical cycle count to REQ-031 case with same adder latency.
REQ-034 start pulsed repeatedly during W1 and FIN -> ignored; single done; next start in IDLE accepted.
REQ-035 resetn low during W2 -> outputs zero same cycle, no done; then M=13 add 7+9 -> 3.
